// File: rtl/hazard_controller_if.sv
// hazard_controller_if: decode-side operands and stage controls between the core pipeline and hazard_controller.
interface hazard_controller_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              valid_d;
    logic [REG_AW-1:0] rs1_addr_d;
    logic [REG_AW-1:0] rs2_addr_d;
    logic              rs1_used_d;
    logic              rs2_used_d;
    logic [REG_AW-1:0] rd_addr_d;
    logic              reg_w_en_d;
    logic              load_d;
    logic              taken_e;
    logic              mem_ready;
    logic              stall_f;
    logic              stall_d;
    logic              stall_emw;
    logic              flush_d;
    logic              flush_e;
    logic [1:0]        fwd_a_e;
    logic [1:0]        fwd_b_e;
    logic              fwd_a_d;
    logic              fwd_b_d;
    logic [CNT_W-1:0]  hazard_cnt;

    modport master (
        output valid_d, rs1_addr_d, rs2_addr_d, rs1_used_d, rs2_used_d,
               rd_addr_d, reg_w_en_d, load_d, taken_e, mem_ready,
        input  stall_f, stall_d, stall_emw, flush_d, flush_e,
               fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, hazard_cnt
    );

    modport slave (
        input  valid_d, rs1_addr_d, rs2_addr_d, rs1_used_d, rs2_used_d,
               rd_addr_d, reg_w_en_d, load_d, taken_e, mem_ready,
        output stall_f, stall_d, stall_emw, flush_d, flush_e,
               fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, hazard_cnt
    );
endinterface

// File: rtl/hazard_controller.sv
// hazard_controller: 5-stage RV32i stall/flush/forwarding control from a shadow E/M/W scoreboard.
// HAZARD_FORWARDING_EN enables E/D forwarding; without it every RAW match stalls until it drains.
module hazard_controller #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input logic                clk,
    input logic                rst_n,
    hazard_controller_if.slave bus
);
    typedef logic [REG_AW-1:0] addr_t;
    typedef struct packed {
        logic  v;
        addr_t rd;
        logic  wen;
        logic  ld;
    } dst_t;

    dst_t             e_q, m_q, w_q;
    addr_t            e_rs1, e_rs2;
    logic [CNT_W-1:0] cnt;
    logic             haz, stall_d, stall_emw, flush_d, flush_e;
    logic             use1, use2;
    logic [1:0]       fa_e, fb_e;
    logic             fa_d, fb_d;

    function automatic logic hit(dst_t s, addr_t rs, logic used);
        return s.v & s.wen & (s.rd != '0) & (s.rd == rs) & used;
    endfunction

    // A bubble in decode reads nothing, so it can never create a hazard.
    assign use1 = bus.valid_d & bus.rs1_used_d;
    assign use2 = bus.valid_d & bus.rs2_used_d;

`ifdef HAZARD_FORWARDING_EN
    always_comb begin
        haz  = e_q.ld & (hit(e_q, bus.rs1_addr_d, use1) | hit(e_q, bus.rs2_addr_d, use2));
        fa_e = (hit(m_q, e_rs1, 1'b1) & ~m_q.ld) ? 2'b10 : hit(w_q, e_rs1, 1'b1) ? 2'b01 : 2'b00;
        fb_e = (hit(m_q, e_rs2, 1'b1) & ~m_q.ld) ? 2'b10 : hit(w_q, e_rs2, 1'b1) ? 2'b01 : 2'b00;
        fa_d = hit(w_q, bus.rs1_addr_d, use1);
        fb_d = hit(w_q, bus.rs2_addr_d, use2);
    end
    logic unused_w_ld;
    assign unused_w_ld = w_q.ld;
`else
    always_comb begin
        haz  = hit(e_q, bus.rs1_addr_d, use1) | hit(e_q, bus.rs2_addr_d, use2) |
               hit(m_q, bus.rs1_addr_d, use1) | hit(m_q, bus.rs2_addr_d, use2) |
               hit(w_q, bus.rs1_addr_d, use1) | hit(w_q, bus.rs2_addr_d, use2);
        fa_e = 2'b00;
        fb_e = 2'b00;
        fa_d = 1'b0;
        fb_d = 1'b0;
    end
    logic unused_fwd;
    assign unused_fwd = ^{e_rs1, e_rs2, e_q.ld, m_q.ld, w_q.ld};
`endif

    // Memory back-pressure beats a taken branch, which beats a data hazard.
    always_comb begin
        stall_emw = rst_n & ~bus.mem_ready;
        stall_d   = rst_n & (~bus.mem_ready | (~bus.taken_e & haz));
        flush_d   = rst_n & bus.mem_ready & bus.taken_e;
        flush_e   = rst_n & bus.mem_ready & (bus.taken_e | haz);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
            e_rs1 <= '0;
            e_rs2 <= '0;
            cnt   <= '0;
        end else if (!stall_emw) begin
            w_q   <= m_q;
            m_q   <= e_q;
            e_q   <= flush_e ? '0 : dst_t'{bus.valid_d, bus.rd_addr_d, bus.reg_w_en_d, bus.load_d};
            e_rs1 <= (use1 & ~flush_e) ? bus.rs1_addr_d : '0;
            e_rs2 <= (use2 & ~flush_e) ? bus.rs2_addr_d : '0;
            if ((stall_d | flush_e) && !(&cnt))
                cnt <= cnt + 1'b1;
        end
    end

    assign bus.stall_f    = stall_d;
    assign bus.stall_d    = stall_d;
    assign bus.stall_emw  = stall_emw;
    assign bus.flush_d    = flush_d;
    assign bus.flush_e    = flush_e;
    assign bus.fwd_a_e    = fa_e;
    assign bus.fwd_b_e    = fb_e;
    assign bus.fwd_a_d    = fa_d;
    assign bus.fwd_b_d    = fb_d;
    assign bus.hazard_cnt = cnt;
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed vectors against an instruction-level pipeline model of hazard_controller.
module tb_hazard_controller;
    localparam int AW   = 5;
    localparam int CW   = 4;
    localparam int CMAX = 15;
`ifdef HAZARD_FORWARDING_EN
    localparam int FWD = 1;
`else
    localparam int FWD = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_controller_if #(.REG_AW(AW), .CNT_W(CW)) bus ();
    hazard_controller #(.REG_AW(AW), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       wen;
        logic       ld;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
    } ins_t;

    ins_t pipe [3] = '{default: '0};
    int   mcnt = 0;
    int   checks = 0;
    int   errors = 0;
    bit   chk_on = 1'b0;
    ins_t din;
    logic hk [3];
    logic haz, x_stall_d, x_stall_emw, x_flush_d, x_flush_e, x_fa_d, x_fb_d;
    logic [1:0] x_fa_e, x_fb_e;

    function automatic logic writes(ins_t s, logic [4:0] r);
        return s.v && s.wen && s.rd != 5'd0 && s.rd == r;
    endfunction

    function automatic logic [1:0] src(ins_t m, ins_t w, logic u, logic [4:0] r);
        if (!u) return 2'd0;
        if (writes(m, r) && !m.ld) return 2'd2;
        if (writes(w, r)) return 2'd1;
        return 2'd0;
    endfunction

    always_comb begin
        din = {bus.valid_d, bus.rd_addr_d, bus.reg_w_en_d, bus.load_d, bus.rs1_addr_d, bus.rs2_addr_d,
               bus.valid_d & bus.rs1_used_d, bus.valid_d & bus.rs2_used_d};
        for (int k = 0; k < 3; k++)
            hk[k] = (din.u1 && writes(pipe[k], din.rs1)) || (din.u2 && writes(pipe[k], din.rs2));
        haz = (FWD != 0) ? (hk[0] && pipe[0].ld) : (hk[0] || hk[1] || hk[2]);
        x_stall_emw = rst_n && !bus.mem_ready;
        x_stall_d   = rst_n && (!bus.mem_ready || (!bus.taken_e && haz));
        x_flush_d   = rst_n && bus.mem_ready && bus.taken_e;
        x_flush_e   = rst_n && bus.mem_ready && (bus.taken_e || haz);
        x_fa_e = (FWD != 0) ? src(pipe[1], pipe[2], pipe[0].u1, pipe[0].rs1) : 2'd0;
        x_fb_e = (FWD != 0) ? src(pipe[1], pipe[2], pipe[0].u2, pipe[0].rs2) : 2'd0;
        x_fa_d = (FWD != 0) && din.u1 && writes(pipe[2], din.rs1);
        x_fb_d = (FWD != 0) && din.u2 && writes(pipe[2], din.rs2);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) pipe[k] <= '0;
            mcnt <= 0;
        end else if (bus.mem_ready) begin
            pipe[2] <= pipe[1];
            pipe[1] <= pipe[0];
            pipe[0] <= x_flush_e ? '0 : din;
            if ((x_stall_d || x_flush_e) && mcnt < CMAX) mcnt <= mcnt + 1;
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("stall_f", {31'd0, bus.stall_f}, {31'd0, x_stall_d});
            chk("stall_d", {31'd0, bus.stall_d}, {31'd0, x_stall_d});
            chk("stall_emw", {31'd0, bus.stall_emw}, {31'd0, x_stall_emw});
            chk("flush_d", {31'd0, bus.flush_d}, {31'd0, x_flush_d});
            chk("flush_e", {31'd0, bus.flush_e}, {31'd0, x_flush_e});
            chk("fwd_a_e", {30'd0, bus.fwd_a_e}, {30'd0, x_fa_e});
            chk("fwd_b_e", {30'd0, bus.fwd_b_e}, {30'd0, x_fb_e});
            chk("fwd_a_d", {31'd0, bus.fwd_a_d}, {31'd0, x_fa_d});
            chk("fwd_b_d", {31'd0, bus.fwd_b_d}, {31'd0, x_fb_d});
            chk("hazard_cnt", {28'd0, bus.hazard_cnt}, mcnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic v, input int rd, input logic wen, input logic ld,
                         input int rs1, input logic u1, input int rs2, input logic u2);
        bus.valid_d    = v;
        bus.rd_addr_d  = rd[4:0];
        bus.reg_w_en_d = wen;
        bus.load_d     = ld;
        bus.rs1_addr_d = rs1[4:0];
        bus.rs1_used_d = u1;
        bus.rs2_addr_d = rs2[4:0];
        bus.rs2_used_d = u2;
    endtask

    task automatic bubble();
        set_d(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    // Present an instruction in decode and hold it until the model lets it enter E.
    task automatic issue(input int rd, input logic wen, input logic ld,
                         input int rs1, input logic u1, input int rs2, input logic u2);
        bit done = 1'b0;
        set_d(1'b1, rd, wen, ld, rs1, u1, rs2, u2);
        for (int n = 0; n < 8 && !done; n++) begin
            logic held;
            #1;
            held = x_stall_d;
            tick();
            done = !held;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL issue_timeout: got stalled expected accepted within 8 cycles");
        end
    endtask

    task automatic drain();
        bubble();
        repeat (3) tick();
    endtask

    initial begin
        bus.taken_e   = 1'b0;
        bus.mem_ready = 1'b1;
        bubble();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall_f", {31'd0, bus.stall_f}, 0);
        chk("rst_flush_e", {31'd0, bus.flush_e}, 0);
        chk("rst_fwd_a_e", {30'd0, bus.fwd_a_e}, 0);
        chk("rst_cnt", {28'd0, bus.hazard_cnt}, 0);
        rst_n  = 1'b1;
        chk_on = 1'b1;

        // addi x5,x0 ; add x6,x5,x5
        issue(5, 1'b1, 1'b0, 0, 1'b1, 0, 1'b0);
        issue(6, 1'b1, 1'b0, 5, 1'b1, 5, 1'b1);
        bubble();
        #1;
        chk("alu_fwd_a", {30'd0, bus.fwd_a_e}, FWD * 2);
        chk("alu_fwd_b", {30'd0, bus.fwd_b_e}, FWD * 2);
        chk("alu_cnt", {28'd0, bus.hazard_cnt}, FWD ? 0 : 3);
        drain();

        // lw x5 ; add x6,x5,x0
        issue(5, 1'b1, 1'b1, 0, 1'b1, 0, 1'b0);
        issue(6, 1'b1, 1'b0, 5, 1'b1, 0, 1'b1);
        bubble();
        #1;
        chk("lu_fwd_a", {30'd0, bus.fwd_a_e}, FWD);
        chk("lu_fwd_b", {30'd0, bus.fwd_b_e}, 0);
        chk("lu_cnt", {28'd0, bus.hazard_cnt}, FWD ? 1 : 6);
        drain();

        // taken branch coinciding with a load-use match
        issue(7, 1'b1, 1'b1, 0, 1'b1, 0, 1'b0);
        set_d(1'b1, 8, 1'b1, 1'b0, 7, 1'b1, 7, 1'b1);
        bus.taken_e = 1'b1;
        #1;
        chk("tk_stall_d", {31'd0, bus.stall_d}, 0);
        chk("tk_flush_d", {31'd0, bus.flush_d}, 1);
        chk("tk_flush_e", {31'd0, bus.flush_e}, 1);
        tick();
        bus.taken_e = 1'b0;
        bubble();
        #1;
        chk("tk_cnt", {28'd0, bus.hazard_cnt}, FWD ? 2 : 7);
        drain();

        // memory not ready for 3 cycles with a taken branch waiting in E
        issue(11, 1'b1, 1'b0, 0, 1'b1, 0, 1'b0);
        bubble();
        bus.taken_e   = 1'b1;
        bus.mem_ready = 1'b0;
        repeat (3) begin
            #1;
            chk("mr_stall_f", {31'd0, bus.stall_f}, 1);
            chk("mr_stall_emw", {31'd0, bus.stall_emw}, 1);
            chk("mr_flush_e", {31'd0, bus.flush_e}, 0);
            tick();
        end
        bus.mem_ready = 1'b1;
        #1;
        chk("mr_rel_flush_e", {31'd0, bus.flush_e}, 1);
        chk("mr_rel_flush_d", {31'd0, bus.flush_d}, 1);
        chk("mr_rel_stall_f", {31'd0, bus.stall_f}, 0);
        tick();
        bus.taken_e = 1'b0;
        #1;
        chk("mr_cnt", {28'd0, bus.hazard_cnt}, FWD ? 3 : 8);
        drain();

        // reset in the middle of a load-use stall
        issue(9, 1'b1, 1'b1, 0, 1'b1, 0, 1'b0);
        set_d(1'b1, 10, 1'b1, 1'b0, 9, 1'b1, 0, 1'b1);
        #1;
        chk("mid_stall_d", {31'd0, bus.stall_d}, 1);
        #1;
        rst_n         = 1'b0;
        bus.mem_ready = 1'b0;
        bus.taken_e   = 1'b1;
        #1;
        chk("rs_stall_f", {31'd0, bus.stall_f}, 0);
        chk("rs_stall_d", {31'd0, bus.stall_d}, 0);
        chk("rs_stall_emw", {31'd0, bus.stall_emw}, 0);
        chk("rs_flush_d", {31'd0, bus.flush_d}, 0);
        chk("rs_flush_e", {31'd0, bus.flush_e}, 0);
        chk("rs_fwd_a_e", {30'd0, bus.fwd_a_e}, 0);
        chk("rs_fwd_a_d", {31'd0, bus.fwd_a_d}, 0);
        chk("rs_cnt", {28'd0, bus.hazard_cnt}, 0);
        tick();
        bus.mem_ready = 1'b1;
        bus.taken_e   = 1'b0;
        bubble();
        rst_n = 1'b1;

        // x0 writer followed by a reader of x0
        issue(0, 1'b1, 1'b0, 0, 1'b1, 0, 1'b0);
        set_d(1'b1, 1, 1'b1, 1'b0, 0, 1'b1, 0, 1'b1);
        #1;
        chk("x0_stall_d", {31'd0, bus.stall_d}, 0);
        tick();
        bubble();
        #1;
        chk("x0_fwd_a_e", {30'd0, bus.fwd_a_e}, 0);
        chk("x0_cnt", {28'd0, bus.hazard_cnt}, 0);
        drain();

        // mixed traffic over a small register window
        for (int i = 0; i < 80; i++) begin
            set_d(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            bus.taken_e   = ($urandom_range(0, 7) == 0);
            bus.mem_ready = ($urandom_range(0, 5) != 0);
            tick();
        end
        bus.taken_e   = 1'b0;
        bus.mem_ready = 1'b1;
        drain();

        // counter saturation
        bus.taken_e = 1'b1;
        repeat (20) tick();
        bus.taken_e = 1'b0;
        #1;
        chk("sat_cnt", {28'd0, bus.hazard_cnt}, CMAX);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
